// File: rtl/sfx_pkg.sv
// Shared constants, state encoding and note payload for the sound-effect sequencer.
package sfx_pkg;

    localparam int unsigned RELOAD_W = 19;
    localparam int unsigned EVT_W    = 2;
    localparam int unsigned STEP_W   = 2;
    localparam int unsigned LEN_W    = 3;
    localparam int unsigned NUM_EVT  = 4;

    localparam logic [RELOAD_W-1:0] N0   = 19'd71303;
    localparam logic [RELOAD_W-1:0] N1   = 19'd118877;
    localparam logic [RELOAD_W-1:0] N2   = 19'd160928;
    localparam logic [RELOAD_W-1:0] N3   = 19'd186270;
    localparam logic [RELOAD_W-1:0] REST = 19'd262143;

    localparam logic [EVT_W-1:0] EVT_MOVE  = 2'd0;
    localparam logic [EVT_W-1:0] EVT_MERGE = 2'd1;
    localparam logic [EVT_W-1:0] EVT_WIN   = 2'd2;
    localparam logic [EVT_W-1:0] EVT_LOSE  = 2'd3;

    localparam logic [LEN_W-1:0] LEN_MOVE  = 3'd1;
    localparam logic [LEN_W-1:0] LEN_MERGE = 3'd2;
    localparam logic [LEN_W-1:0] LEN_WIN   = 3'd4;
    localparam logic [LEN_W-1:0] LEN_LOSE  = 3'd4;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    typedef struct packed {
        logic [RELOAD_W-1:0] reload;
        logic [LEN_W-1:0]    len;
    } note_t;

    // Index of the highest set bit (priority lose > win > merge > move)
    function automatic logic [EVT_W-1:0] hi_idx(input logic [NUM_EVT-1:0] v);
        logic [EVT_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_EVT; i++) begin
            if (v[i]) r = EVT_W'(i);
        end
        return r;
    endfunction

    function automatic logic [NUM_EVT-1:0] onehot(input logic [EVT_W-1:0] e);
        return NUM_EVT'(1) << e;
    endfunction

    // Bits strictly above index e
    function automatic logic [NUM_EVT-1:0] gt_mask(input logic [EVT_W-1:0] e);
        return ~((NUM_EVT'(2) << e) - NUM_EVT'(1));
    endfunction

endpackage

// File: rtl/sfx_note_rom.sv
// Combinational note table: (event, step) -> reload value and sequence length.
import sfx_pkg::*;

module sfx_note_rom (
    input  logic [EVT_W-1:0]  evt,
    input  logic [STEP_W-1:0] step,
    output note_t             note
);

    always_comb begin
        note.reload = REST;
        note.len    = LEN_MOVE;
        unique case (evt)
            EVT_MOVE: begin
                note.len    = LEN_MOVE;
                note.reload = N0;
            end
            EVT_MERGE: begin
                note.len    = LEN_MERGE;
                note.reload = (step == 2'd0) ? N1 : N2;
            end
            EVT_WIN: begin
                note.len = LEN_WIN;
                unique case (step)
                    2'd0: note.reload = N0;
                    2'd1: note.reload = N1;
                    2'd2: note.reload = N2;
                    2'd3: note.reload = N3;
                endcase
            end
            EVT_LOSE: begin
                note.len = LEN_LOSE;
                unique case (step)
                    2'd0: note.reload = N3;
                    2'd1: note.reload = N2;
                    2'd2: note.reload = N1;
                    2'd3: note.reload = N0;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: arbitrates event pulses and steps note/gap timing
// into the square-wave tone generator.
import sfx_pkg::*;

module sfx_sequencer #(
    parameter int unsigned NOTE_TICKS = 25_000_000,
    parameter int unsigned GAP_TICKS  = 2_500_000,
    parameter int unsigned CNT_W      = 25
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mute,
    input  logic [NUM_EVT-1:0]  req,
    output logic [RELOAD_W-1:0] reload,
    output logic                tone_en,
    output logic                busy,
    output logic [EVT_W-1:0]    cur_evt,
    output logic                done
);

    state_t               state_q, state_d;
    logic [NUM_EVT-1:0]   pending_q, pending_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RELOAD_W-1:0]  reload_d;
    logic                 tone_d, done_d;
    logic [EVT_W-1:0]     cur_d, sel;
    logic [NUM_EVT-1:0]   req_all, above;
    logic                 preempt;
    note_t                note;

    sfx_note_rom u_rom (
        .evt  (cur_evt),
        .step (step_q),
        .note (note)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            step_q    <= '0;
            cnt_q     <= '0;
            reload    <= REST;
            tone_en   <= 1'b0;
            busy      <= 1'b0;
            cur_evt   <= '0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            reload    <= reload_d;
            tone_en   <= tone_d;
            busy      <= (state_d != IDLE);
            cur_evt   <= cur_d;
            done      <= done_d;
        end
    end

    // Arbitration, preemption and note/gap timing
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        reload_d  = reload;
        tone_d    = tone_en;
        cur_d     = cur_evt;
        done_d    = 1'b0;

        req_all = req | pending_q;
        above   = req_all & gt_mask(cur_evt);
        preempt = (state_q != IDLE) && (above != '0);
        sel     = hi_idx((state_q == IDLE) ? req_all : above);

        if (mute) begin
            state_d   = IDLE;
            tone_d    = 1'b0;
            reload_d  = REST;
            pending_d = '0;
        end else if (preempt) begin
            // Preempted event is dropped; a same-index request is discarded
            state_d   = LOAD;
            cur_d     = sel;
            step_d    = '0;
            tone_d    = 1'b0;
            reload_d  = REST;
            pending_d = req_all & ~onehot(sel) & ~onehot(cur_evt);
        end else begin
            unique case (state_q)
                IDLE: begin
                    pending_d = req_all;
                    if (req_all != '0) begin
                        state_d   = LOAD;
                        cur_d     = sel;
                        step_d    = '0;
                        pending_d = req_all & ~onehot(sel);
                    end
                end
                LOAD: begin
                    pending_d = req_all & ~onehot(cur_evt);
                    reload_d  = note.reload;
                    cnt_d     = CNT_W'(NOTE_TICKS - 1);
                    tone_d    = 1'b1;
                    state_d   = PLAY;
                end
                PLAY: begin
                    pending_d = req_all & ~onehot(cur_evt);
                    if (cnt_q == '0) begin
                        tone_d   = 1'b0;
                        reload_d = REST;
                        cnt_d    = CNT_W'(GAP_TICKS - 1);
                        state_d  = GAP;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                GAP: begin
                    pending_d = req_all & ~onehot(cur_evt);
                    if (cnt_q == '0) begin
                        if ((LEN_W'(step_q) + LEN_W'(1)) < note.len) begin
                            step_d  = step_q + STEP_W'(1);
                            state_d = LOAD;
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Scoreboard bench for sfx_sequencer: expected notes and done pulses are queued
// by the stimulus and consumed by a negedge monitor.
module tb_sfx_sequencer;

    localparam int NT = 4;
    localparam int GT = 2;
    localparam int RST_V = 262143;
    localparam int V0 = 71303;
    localparam int V1 = 118877;
    localparam int V2 = 160928;
    localparam int V3 = 186270;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mute = 1'b0;
    logic [3:0]  req = 4'h0;
    logic [18:0] reload;
    logic        tone_en;
    logic        busy;
    logic [1:0]  cur_evt;
    logic        done;

    sfx_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(GT), .CNT_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mute    (mute),
        .req     (req),
        .reload  (reload),
        .tone_en (tone_en),
        .busy    (busy),
        .cur_evt (cur_evt),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rl;
        int evt;
        int hi;
        int pre;
    } note_exp_t;

    note_exp_t nq[$];
    int        dq[$];
    int        errors = 0;
    int        checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_note(input int rl, input int evt, input int hi, input int pre);
        note_exp_t e;
        e.rl = rl; e.evt = evt; e.hi = hi; e.pre = pre;
        nq.push_back(e);
    endfunction

    // Monitor: compares tone runs and done pulses against the queues
    logic tone_prev = 1'b0;
    int   hi_run = 0;
    int   low_run = 0;
    int   hi_exp = 0;
    always @(negedge clk) begin
        note_exp_t e;
        if (!rst_n) begin
            tone_prev = 1'b0;
            hi_run = 0;
            low_run = 0;
        end else begin
            if (done) begin
                if (dq.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("done_evt", int'(cur_evt), dq.pop_front());
                    check("done_gap_len", low_run, GT);
                    check("done_busy", int'(busy), 0);
                end
            end
            if (tone_en && !tone_prev) begin
                if (nq.size() == 0) begin
                    check("unexpected_note", 1, 0);
                    hi_exp = 0;
                end else begin
                    e = nq.pop_front();
                    check("note_reload", int'(reload), e.rl);
                    check("note_evt", int'(cur_evt), e.evt);
                    if (e.pre > 0) check("note_pre_low", low_run, e.pre);
                    hi_exp = e.hi;
                end
                hi_run = 1;
            end else if (tone_en) begin
                hi_run++;
            end
            if (!tone_en && tone_prev) check("note_len", hi_run, hi_exp);
            low_run = tone_en ? 0 : low_run + 1;
            tone_prev = tone_en;
        end
    end

    task automatic pulse(input logic [3:0] v);
        @(negedge clk);
        req = v;
        @(negedge clk);
        req = 4'h0;
    endtask

    task automatic wait_tone();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tone_en && n < 100);
        if (!tone_en) check("wait_tone_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || done || nq.size() != 0 || dq.size() != 0) && n < 300);
        if (busy) check("wait_idle_timeout", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int  lat;
        logic saw_busy;

        // 1: reset with all requests asserted
        req = 4'hF;
        repeat (4) @(negedge clk);
        check("rst_reload", int'(reload), RST_V);
        check("rst_tone_en", int'(tone_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cur_evt", int'(cur_evt), 0);
        rst_n = 1'b1;
        req = 4'h0;
        repeat (5) @(negedge clk);
        check("post_rst_idle", int'(busy), 0);

        // 2: move, with request-to-tone latency
        push_note(V0, 0, NT, 0);
        dq.push_back(0);
        @(negedge clk);
        req = 4'b0001;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) req = 4'h0;
            if (tone_en) begin
                lat = n;
                break;
            end
        end
        check("move_latency", lat, 2);
        wait_idle();

        // 3: win, four notes
        push_note(V0, 2, NT, 0);
        push_note(V1, 2, NT, GT + 1);
        push_note(V2, 2, NT, GT + 1);
        push_note(V3, 2, NT, GT + 1);
        dq.push_back(2);
        pulse(4'b0100);
        wait_idle();

        // 4: lose preempts merge on its first note
        push_note(V1, 1, 1, 0);
        push_note(V3, 3, NT, 1);
        push_note(V2, 3, NT, GT + 1);
        push_note(V1, 3, NT, GT + 1);
        push_note(V0, 3, NT, GT + 1);
        dq.push_back(3);
        pulse(4'b0010);
        wait_tone();
        req = 4'b1000;
        @(negedge clk);
        req = 4'h0;
        wait_idle();

        // 5: move+merge while lose plays, served afterwards highest first
        push_note(V3, 3, NT, 0);
        push_note(V2, 3, NT, GT + 1);
        push_note(V1, 3, NT, GT + 1);
        push_note(V0, 3, NT, GT + 1);
        dq.push_back(3);
        push_note(V1, 1, NT, GT + 2);
        push_note(V2, 1, NT, GT + 1);
        dq.push_back(1);
        push_note(V0, 0, NT, GT + 2);
        dq.push_back(0);
        pulse(4'b1000);
        wait_tone();
        req = 4'b0011;
        @(negedge clk);
        req = 4'h0;
        wait_idle();

        // 6: mute during win note, with a pending move and a request under mute
        push_note(V0, 2, 3, 0);
        pulse(4'b0100);
        wait_tone();
        req = 4'b0001;
        @(negedge clk);
        req = 4'h0;
        @(negedge clk);
        mute = 1'b1;
        req = 4'b0010;
        @(negedge clk);
        mute = 1'b0;
        req = 4'h0;
        check("mute_tone_en", int'(tone_en), 0);
        check("mute_busy", int'(busy), 0);
        check("mute_reload", int'(reload), RST_V);
        check("mute_done", int'(done), 0);
        saw_busy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy || done) saw_busy = 1'b1;
        end
        check("mute_cleared_pending", int'(saw_busy), 0);

        check("notes_left", nq.size(), 0);
        check("dones_left", dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
